// File: rtl/rs232_rx_fifo.sv
// Byte FIFO behind the RS-232 receiver: one byte is taken per rdy/done handshake, with first-word-fall-through reads.
// A byte is visible on dout/avail the cycle after capture; when full, incoming bytes are dropped and flagged in sticky ovr.
module rs232_rx_fifo #(
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rx_rdy,
  input  logic [7:0]    rx_data,
  output logic          rx_done,
  input  logic          rd,
  output logic [7:0]    dout,
  output logic          avail,
  output logic          full,
  output logic [AW:0]   count,
  output logic          ovr,
  input  logic          ovr_clr
);

  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, ACK, WAIT} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic          take;
  logic          pop;
  logic          wr;

  assign avail = (count != '0);
  assign full  = (count == CNT_FULL);
  assign pop   = rd && avail;
  assign take  = (state == IDLE) && rx_rdy;
  // A full FIFO still accepts the byte when a pop frees the head slot in the same cycle.
  assign wr    = take && (!full || pop);
  assign dout  = mem[rp];

  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      rx_done <= 1'b0;
      wp      <= '0;
      rp      <= '0;
      count   <= '0;
      ovr     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (rx_rdy) begin
            rx_done <= 1'b1;
            state   <= ACK;
          end
        end
        ACK: begin
          rx_done <= 1'b0;
          state   <= WAIT;
        end
        WAIT: begin
          // Hold off until the receiver drops rdy so the same byte is never taken twice.
          if (!rx_rdy) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      if (wr)  wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);

      case ({wr, pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase

      if (take && !wr)  ovr <= 1'b1;
      else if (ovr_clr) ovr <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rs232_rx_fifo.sv
// Randomized scoreboard bench for rs232_rx_fifo: a queue model predicts contents, count and overrun.
module tb_rs232_rx_fifo;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          rx_rdy;
  logic [7:0]    rx_data;
  logic          rx_done;
  logic          rd;
  logic [7:0]    dout;
  logic          avail;
  logic          full;
  logic [AW:0]   count;
  logic          ovr;
  logic          ovr_clr;

  int            n_chk = 0;
  int            n_err = 0;
  int            exp_cnt = 0;
  bit            exp_ovr = 1'b0;
  byte unsigned  sb_q[$];
  logic [7:0]    last_dout = 8'h00;

  rs232_rx_fifo #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data), .rx_done(rx_done),
    .rd(rd), .dout(dout), .avail(avail), .full(full), .count(count),
    .ovr(ovr), .ovr_clr(ovr_clr)
  );

  always #20 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, "_count"}, int'(count), exp_cnt);
    chk({tag, "_avail"}, int'(avail), int'(exp_cnt != 0));
    chk({tag, "_full"},  int'(full),  int'(exp_cnt == DEPTH));
    chk({tag, "_ovr"},   int'(ovr),   int'(exp_ovr));
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted pop must present the oldest expected byte on dout.
  always @(negedge clk) begin
    if (!rst && rd && avail) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL pop_underflow: dout=%0d popped with no byte expected", dout);
      end else begin
        last_dout = dout;
        chk("pop_data", int'(dout), int'(sb_q.pop_front()));
      end
    end
  end

  task automatic do_reset(input int n);
    rst = 1'b1; rx_rdy = 1'b0; rd = 1'b0; ovr_clr = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
    exp_cnt = 0; exp_ovr = 1'b0; sb_q.delete();
    chk_state("reset");
    chk("reset_rx_done", int'(rx_done), 0);
  endtask

  // One full receiver handshake; the byte is taken at the first edge, optionally with a pop/clear in that cycle.
  task automatic send(input logic [7:0] d, input bit pop, input bit clr, input int hold);
    bit pv;
    bit acc;
    rx_rdy = 1'b1; rx_data = d; rd = pop; ovr_clr = clr;
    pv  = pop && (exp_cnt > 0);
    acc = (exp_cnt < DEPTH) || pv;
    tick();
    rd = 1'b0; ovr_clr = 1'b0;
    if (acc) begin
      sb_q.push_back(d);
      if (clr) exp_ovr = 1'b0;
    end else begin
      exp_ovr = 1'b1;
    end
    exp_cnt += int'(acc) - int'(pv);
    chk("rx_done_pulse", int'(rx_done), 1);
    chk_state("capture");
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("rx_done_hold", int'(rx_done), 0);
      chk_state("hold");
    end
    rx_rdy = 1'b0;
    tick();
    chk("rx_done_fall", int'(rx_done), 0);
    tick();
  endtask

  task automatic pop1();
    bit pv;
    pv = (exp_cnt > 0);
    rd = 1'b1;
    tick();
    rd = 1'b0;
    exp_cnt -= int'(pv);
    chk_state("pop");
  endtask

  task automatic clear_ovr();
    ovr_clr = 1'b1;
    tick();
    ovr_clr = 1'b0;
    exp_ovr = 1'b0;
    chk("ovr_clr", int'(ovr), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; rx_rdy = 1'b0; rx_data = 8'h00; rd = 1'b0; ovr_clr = 1'b0;
    do_reset(2);

    // Single byte, then pop it.
    send(8'hA5, 1'b0, 1'b0, 0);
    chk("dout_a5", int'(dout), 8'hA5);
    pop1();

    // Long rdy after done: still one write.
    send(8'h3C, 1'b0, 1'b0, 10);
    chk("long_rdy_count", int'(count), 1);
    pop1();

    // Fill, overrun, set-beats-clear, drain in order.
    for (int i = 0; i < DEPTH; i++) send(8'(i), 1'b0, 1'b0, 0);
    chk("fill_full", int'(full), 1);
    send(8'hFF, 1'b0, 1'b0, 0);
    send(8'hFE, 1'b0, 1'b1, 0);
    chk("ovr_sticky", int'(ovr), 1);
    for (int i = 0; i < DEPTH; i++) pop1();
    clear_ovr();
    pop1();

    // Full plus simultaneous pop: write accepted, 8'h77 last out.
    for (int i = 0; i < DEPTH; i++) send(8'(8'h10 + i), 1'b0, 1'b0, 0);
    send(8'h77, 1'b1, 1'b0, 0);
    for (int i = 0; i < DEPTH; i++) pop1();
    chk("last_pop_77", int'(last_dout), 8'h77);

    // Wrap-around with shallow occupancy.
    for (int i = 0; i < 40; i++) begin
      send(8'(i), 1'b0, 1'b0, 0);
      if (exp_cnt == 3) pop1();
    end
    while (exp_cnt > 0) pop1();

    // Randomized mix of bytes, pops and clears.
    for (int i = 0; i < 120; i++) begin
      case ($urandom_range(0, 3))
        0, 1: send(8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(0, 3) == 0, $urandom_range(0, 2));
        2:    pop1();
        default: clear_ovr();
      endcase
    end
    while (exp_cnt > 0) pop1();
    clear_ovr();

    // Reset in the ACK cycle with five bytes stored.
    for (int i = 0; i < 4; i++) send(8'(8'hC0 + i), 1'b0, 1'b0, 0);
    rx_rdy = 1'b1; rx_data = 8'h5A;
    tick();
    sb_q.push_back(8'h5A);
    exp_cnt = 5;
    chk("ack_count", int'(count), 5);
    chk("ack_rx_done", int'(rx_done), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    sb_q.delete(); exp_cnt = 0; exp_ovr = 1'b0;
    chk_state("midrst");
    chk("midrst_rx_done", int'(rx_done), 0);
    tick();
    sb_q.push_back(8'h5A);
    exp_cnt = 1;
    chk("retake_rx_done", int'(rx_done), 1);
    chk_state("retake");
    rx_rdy = 1'b0;
    tick();
    tick();
    chk_state("retake_once");
    pop1();
    chk("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
